// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over buffered multi-cycle results.
// Optional WB_ARB_BYPASS_EN: grant an mc result directly when the FIFO is empty and the pipe is idle.
module wb_port_arbiter #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RF_ADDRESS = 5,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned STARVE_MAX = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pipe_we,
    input  logic [RF_ADDRESS-1:0] pipe_rd,
    input  logic [DATA_W-1:0]     pipe_wdata,
    input  logic                  mc_valid,
    output logic                  mc_ready,
    input  logic [RF_ADDRESS-1:0] mc_rd,
    input  logic [DATA_W-1:0]     mc_wdata,
    output logic                  stall_pipe,
    output logic                  rf_we,
    output logic [RF_ADDRESS-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned StW  = $clog2(STARVE_MAX + 1);

    typedef enum logic [0:0] {StNormal, StForce} state_e;

    state_e                state_q, state_d;
    logic [StW-1:0]        starve_q, starve_d;
    logic [CntW-1:0]       count_q;
    logic [PtrW-1:0]       rptr_q, wptr_q;
    logic [RF_ADDRESS-1:0] rd_mem [DEPTH];
    logic [DATA_W-1:0]     data_mem [DEPTH];

    logic                  empty, full, push, pop, grant, bypass;
    logic [RF_ADDRESS-1:0] grant_rd;
    logic [DATA_W-1:0]     grant_data;

    assign empty      = (count_q == '0);
    assign full       = (count_q == CntW'(DEPTH));
    assign mc_ready   = !full;
    assign stall_pipe = (state_q == StForce);
    assign push       = mc_valid && !full && !bypass;

    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        pop        = 1'b0;
        grant      = 1'b0;
        bypass     = 1'b0;
        grant_rd   = '0;
        grant_data = '0;
        case (state_q)
            StForce: begin
                pop        = 1'b1;
                grant      = 1'b1;
                grant_rd   = rd_mem[rptr_q];
                grant_data = data_mem[rptr_q];
                starve_d   = '0;
                state_d    = StNormal;
            end
            default: begin
                if (pipe_we) begin
                    grant      = 1'b1;
                    grant_rd   = pipe_rd;
                    grant_data = pipe_wdata;
                    if (empty) begin
                        starve_d = '0;
                    end else if (starve_q == StW'(STARVE_MAX - 1)) begin
                        starve_d = '0;
                        state_d  = StForce;
                    end else begin
                        starve_d = starve_q + StW'(1);
                    end
                end else if (!empty) begin
                    pop        = 1'b1;
                    grant      = 1'b1;
                    grant_rd   = rd_mem[rptr_q];
                    grant_data = data_mem[rptr_q];
                    starve_d   = '0;
                end else begin
                    starve_d = '0;
`ifdef WB_ARB_BYPASS_EN
                    if (mc_valid) begin
                        bypass     = 1'b1;
                        grant      = 1'b1;
                        grant_rd   = mc_rd;
                        grant_data = mc_wdata;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StNormal;
            starve_q <= '0;
            count_q  <= '0;
            rptr_q   <= '0;
            wptr_q   <= '0;
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
            // Writes to x0 are consumed but never reach the register file.
            rf_we <= grant && (grant_rd != '0);
            if (grant && (grant_rd != '0)) begin
                rf_waddr <= grant_rd;
                rf_wdata <= grant_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wptr_q]   <= mc_rd;
            data_mem[wptr_q] <= mc_wdata;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter (default parameters).
// Expected mc latency follows WB_ARB_BYPASS_EN when the bench is built with it.
module tb_wb_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_we;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_wdata;
    logic        mc_valid;
    logic        mc_ready;
    logic [4:0]  mc_rd;
    logic [31:0] mc_wdata;
    logic        stall_pipe;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_port_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .pipe_we    (pipe_we),
        .pipe_rd    (pipe_rd),
        .pipe_wdata (pipe_wdata),
        .mc_valid   (mc_valid),
        .mc_ready   (mc_ready),
        .mc_rd      (mc_rd),
        .mc_wdata   (mc_wdata),
        .stall_pipe (stall_pipe),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_port(input string tag, input logic we, input logic [4:0] addr,
                              input logic [31:0] data);
        check_eq({tag, "_we"}, 32'(rf_we), 32'(we));
        check_eq({tag, "_addr"}, 32'(rf_waddr), 32'(addr));
        check_eq({tag, "_data"}, rf_wdata, data);
    endtask

    initial begin
        reset = 1'b1; pipe_we = 1'b0; pipe_rd = '0; pipe_wdata = '0;
        mc_valid = 1'b0; mc_rd = '0; mc_wdata = '0;
        step(); step();
        check_port("rst", 1'b0, 5'd0, 32'h0);
        check_eq("rst_stall", 32'(stall_pipe), 32'd0);
        check_eq("rst_ready", 32'(mc_ready), 32'd1);
        reset = 1'b0;

        // Pipeline write, one cycle latency
        pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wdata = 32'hA5A5_A5A5;
        step();
        pipe_we = 1'b0;
        check_port("pipe", 1'b1, 5'd5, 32'hA5A5_A5A5);

        // Single multi-cycle result, pipe idle
        mc_valid = 1'b1; mc_rd = 5'd7; mc_wdata = 32'h1234;
        step();
        mc_valid = 1'b0;
`ifdef WB_ARB_BYPASS_EN
        check_port("mc_byp", 1'b1, 5'd7, 32'h1234);
`else
        check_eq("mc_lat1_we", 32'(rf_we), 32'd0);
        step();
        check_port("mc_lat2", 1'b1, 5'd7, 32'h1234);
`endif
        step();
        check_eq("mc_idle_we", 32'(rf_we), 32'd0);

        // Starvation: 4 pushes under continuous pipe writes, FORCE after 8 wins
        for (int i = 0; i < 9; i++) begin
            pipe_we = 1'b1; pipe_rd = 5'd3; pipe_wdata = 32'hBEEF_0000 + 32'(i);
            mc_valid = (i < 4); mc_rd = 5'(10 + i); mc_wdata = 32'h100 + 32'(i);
            step();
            if (i == 3) check_eq("full_ready", 32'(mc_ready), 32'd0);
            if (i == 7) check_eq("pre_force_stall", 32'(stall_pipe), 32'd0);
        end
        mc_valid = 1'b0;
        check_eq("force_stall", 32'(stall_pipe), 32'd1);
        check_port("force_pre", 1'b1, 5'd3, 32'hBEEF_0008);
        step();
        check_eq("force_end_stall", 32'(stall_pipe), 32'd0);
        check_eq("force_ready", 32'(mc_ready), 32'd1);
        check_port("force_pop", 1'b1, 5'd10, 32'h100);
        step();
        pipe_we = 1'b0;
        check_port("pipe_after_force", 1'b1, 5'd3, 32'hBEEF_0008);
        for (int i = 1; i < 4; i++) begin
            step();
            check_port("drain", 1'b1, 5'(10 + i), 32'h100 + 32'(i));
        end

        // rd==0 writes are consumed silently
        pipe_we = 1'b1; pipe_rd = 5'd0; pipe_wdata = 32'hFFFF_FFFF;
        step();
        pipe_we = 1'b0;
        check_port("pipe_x0", 1'b0, 5'd13, 32'h103);
        mc_valid = 1'b1; mc_rd = 5'd0; mc_wdata = 32'hDEAD;
        step();
        mc_valid = 1'b0;
        check_eq("mc_x0_a_we", 32'(rf_we), 32'd0);
        step();
        check_port("mc_x0_b", 1'b0, 5'd13, 32'h103);

        // Fill to DEPTH-1, then push and pop together for 10 cycles
        for (int k = 0; k < 3; k++) begin
            pipe_we = 1'b1; pipe_rd = 5'd2; pipe_wdata = 32'(k);
            mc_valid = 1'b1; mc_rd = 5'(16 + k); mc_wdata = 32'hC000 + 32'(k);
            step();
        end
        pipe_we = 1'b0;
        check_eq("fill3_ready", 32'(mc_ready), 32'd1);
        for (int j = 0; j < 10; j++) begin
            mc_valid = 1'b1; mc_rd = 5'(19 + j); mc_wdata = 32'hC003 + 32'(j);
            step();
            check_port("pushpop", 1'b1, 5'(16 + j), 32'hC000 + 32'(j));
            check_eq("pushpop_ready", 32'(mc_ready), 32'd1);
        end
        mc_valid = 1'b0;
        for (int j = 10; j < 13; j++) begin
            step();
            check_port("tail", 1'b1, 5'(16 + j), 32'hC000 + 32'(j));
        end
        step();
        check_eq("empty_we", 32'(rf_we), 32'd0);

        // Reset with 3 entries buffered
        for (int k = 0; k < 3; k++) begin
            pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wdata = 32'h55;
            mc_valid = 1'b1; mc_rd = 5'(20 + k); mc_wdata = 32'(k);
            step();
        end
        pipe_we = 1'b0; mc_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_port("mid_rst", 1'b0, 5'd0, 32'h0);
        check_eq("mid_rst_ready", 32'(mc_ready), 32'd1);
        check_eq("mid_rst_stall", 32'(stall_pipe), 32'd0);
        step();
        reset = 1'b0;
        step();
        check_eq("post_rst_we1", 32'(rf_we), 32'd0);
        step();
        check_eq("post_rst_we2", 32'(rf_we), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
